// File: rtl/hit_resolve.sv
// Closest-hit resolver: keeps the nearest positive-t triangle per pixel and
// writes its normal as an RGB444 colour. Optional stats: HIT_RESOLVE_STATS_EN.
module hit_resolve #(
  parameter int          TOTAL_PREC     = 27,
  parameter int          FRAC_BITS      = 22,
  parameter int          TOTAL_PREC_ROT = 18,
  parameter int          FRAC_BITS_ROT  = 13,
  parameter logic [11:0] BG_COLOR       = 12'h000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [19:0]                      fb_addr,
  input  logic                             hit,
  input  logic signed [TOTAL_PREC-1:0]     t,
  input  logic signed [TOTAL_PREC_ROT-1:0] n [2:0],
  input  logic                             last_tri,
  input  logic                             last_pix,
  output logic                             fb_we,
  output logic [19:0]                      fb_waddr,
  output logic [11:0]                      fb_wdata,
  output logic                             frame_done,
  output logic                             state_dbg
`ifdef HIT_RESOLVE_STATS_EN
  ,
  output logic [19:0]                      hit_count
`endif
);

  // Input handshake: a beat is consumed on every rising edge where in_valid=1.
  // There is no ready; the upstream pipeline never stalls.

  localparam int NSHIFT = FRAC_BITS_ROT - 3;
  localparam int NW     = TOTAL_PREC_ROT + 1;
  localparam logic signed [NW-1:0] NIB_OFFS = NW'(8);
  localparam logic signed [NW-1:0] NIB_MAX  = NW'(15);

  if (FRAC_BITS >= TOTAL_PREC || FRAC_BITS_ROT < 3 ||
      FRAC_BITS_ROT >= TOTAL_PREC_ROT) begin : g_param_check
    $error("hit_resolve: inconsistent fixed-point parameters");
  end

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nx;

  logic                             have_hit;
  logic signed [TOTAL_PREC-1:0]     best_t;
  logic signed [TOTAL_PREC_ROT-1:0] best_n [2:0];

  logic                             cand;
  logic                             take;
  logic                             resolve;
  logic                             mrg_hit;
  logic signed [TOTAL_PREC_ROT-1:0] mrg_n [2:0];
  logic [11:0]                      color;

  // Scale a normal component to a 4-bit colour channel centred on 8.
  function automatic logic [3:0] to_nib(input logic signed [TOTAL_PREC_ROT-1:0] v);
    logic signed [NW-1:0] s;
    s = {v[TOTAL_PREC_ROT-1], v};
    s = (s >>> NSHIFT) + NIB_OFFS;
    if (s[NW-1])
      return 4'h0;
    else if (s > NIB_MAX)
      return 4'hF;
    else
      return s[3:0];
  endfunction

  always_comb begin
    state_nx = state;
    cand     = 1'b0;
    take     = 1'b0;
    resolve  = 1'b0;
    mrg_hit  = have_hit;
    for (int k = 0; k < 3; k++) mrg_n[k] = best_n[k];

    unique case (state)
      SYNC: begin
        if (in_valid && last_tri && last_pix) state_nx = RUN;
      end
      RUN: begin
        // t > 0: sign bit clear and not zero.
        cand    = in_valid && hit && !t[TOTAL_PREC-1] && (t != '0);
        take    = cand && (!have_hit || (t < best_t));
        resolve = in_valid && last_tri;
        if (take) begin
          mrg_hit = 1'b1;
          for (int k = 0; k < 3; k++) mrg_n[k] = n[k];
        end
      end
      default: state_nx = SYNC;
    endcase

    color = mrg_hit ? {to_nib(mrg_n[0]), to_nib(mrg_n[1]), to_nib(mrg_n[2])}
                    : BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SYNC;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      fb_waddr   <= '0;
      fb_wdata   <= '0;
      have_hit   <= 1'b0;
      best_t     <= '0;
      for (int k = 0; k < 3; k++) best_n[k] <= '0;
    end else begin
      state      <= state_nx;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      if (resolve) begin
        fb_we      <= 1'b1;
        fb_waddr   <= fb_addr;
        fb_wdata   <= color;
        frame_done <= last_pix;
        have_hit   <= 1'b0;
        best_t     <= '0;
        for (int k = 0; k < 3; k++) best_n[k] <= '0;
      end else if (take) begin
        have_hit <= 1'b1;
        best_t   <= t;
        for (int k = 0; k < 3; k++) best_n[k] <= n[k];
      end
    end
  end

  assign state_dbg = state;

`ifdef HIT_RESOLVE_STATS_EN
  logic [19:0] hit_cnt;

  // hit_count is published on the same edge that raises frame_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt   <= '0;
      hit_count <= '0;
    end else if (resolve) begin
      if (last_pix) begin
        hit_count <= hit_cnt + {19'b0, mrg_hit};
        hit_cnt   <= '0;
      end else begin
        hit_cnt <= hit_cnt + {19'b0, mrg_hit};
      end
    end
  end
`endif

endmodule

// File: doc/hit_resolve.md
HIT_RESOLVE -- requirements
Module: hit_resolve

Interface
REQ-001 SHALL have parameters (name, default, meaning): TOTAL_PREC, 27, width of hit distance t; FRAC_BITS, 22, fractional bits of t; TOTAL_PREC_ROT, 18, width of normal components; FRAC_BITS_ROT, 13, fractional bits of normals; BG_COLOR, 12'h000, RGB444 colour written for a miss.
REQ-002 SHALL have ports (name, direction, width, meaning): clk, in, 1, sole clock; reset is synchronous and active-low.
REQ-003 rst_n, in, 1, synchronous active-low reset.
REQ-004 in_valid, in, 1, one triangle-test beat present.
REQ-005 fb_addr, in, 20, pixel address of beat.
REQ-006 hit, in, 1, ray hit the triangle.
REQ-007 t, in, TOTAL_PREC signed, hit distance.
REQ-008 n[2:0], in, TOTAL_PREC_ROT signed each, triangle normal.
REQ-009 last_tri, in, 1, final triangle for this pixel.
REQ-010 last_pix, in, 1, final pixel of frame.
REQ-011 fb_we, out, 1, framebuffer write strobe.
REQ-012 fb_waddr, out, 20, write address.
REQ-013 fb_wdata, out, 12, RGB444 pixel.
REQ-014 frame_done, out, 1, one-cycle pulse after last pixel of a frame is written.

Function
REQ-015 SHALL run FSM states SYNC and RUN; SYNC ignores beats until a valid beat with last_tri=1 and last_pix=1, then enters RUN on the next cycle without writing.
REQ-016 In RUN, a beat is a candidate only if in_valid=1, hit=1 and t>0; t<=0 or hit=0 is a miss.
REQ-017 SHALL keep best_t/best_n/have_hit per pixel; candidate replaces best only if !have_hit or t<best_t (strictly less; equal t keeps earlier triangle).
REQ-018 The beat carrying last_tri SHALL be included in the comparison before resolution; accumulators clear on the same edge for the next pixel.
REQ-019 One cycle after a valid last_tri beat, fb_we=1 for exactly one cycle with fb_waddr = fb_addr of that beat.
REQ-020 fb_wdata: if no candidate, BG_COLOR; else per component k (R=n[0], G=n[1], B=n[2]) c_k = saturate to [0,15] of ((best_n[k] >>> (FRAC_BITS_ROT-3)) + 8).
REQ-021 frame_done SHALL pulse in the same cycle as the fb_we for a beat with last_pix=1.
REQ-022 Beats with in_valid=0 SHALL not alter any state; no backpressure exists.
REQ-023 Single-beat pixels (first beat has last_tri=1) SHALL resolve from that beat alone.
REQ-024 fb_addr changing without last_tri SHALL not trigger a write; address used is the last_tri beat's.

Reset
REQ-025 rst_n=0 sampled on a rising clk edge SHALL set state=SYNC, fb_we=0, frame_done=0, fb_waddr=0, fb_wdata=0, have_hit=0, best_t=0, best_n=0.
REQ-026 Reset mid-pixel or mid-frame SHALL discard partial accumulation; no write issues until a fresh frame end is seen in SYNC.

Configuration
REQ-027 With HIT_RESOLVE_STATS_EN defined: extra output hit_count[19:0], counting pixels written with a candidate in current frame, latched to hit_count on frame_done and internal counter cleared; reset value 0.
REQ-028 Without HIT_RESOLVE_STATS_EN: port and counter absent; all other behaviour identical.

Verification
REQ-029 Reset, then beats with last_tri=0, then beat last_tri=1,last_pix=1 -> no fb_we; next pixel resolves normally (SYNC exit).
REQ-030 RUN, pixel 5: hits t=300,100(n=8192,0,0),200 with last_tri on third -> fb_we next cycle, fb_waddr=5, fb_wdata=12'hF88.
REQ-031 Pixel 7: all hit=0, or hit=1 with t=0 or t=-5 -> fb_wdata=BG_COLOR.
REQ-032 Two hits with equal t=50, normals (0,8192,0) then (0,0,8192) -> fb_wdata=12'h8F8 (first kept).
REQ-033 Normal (-8192,0,0) single-beat pixel with last_pix=1 -> fb_wdata=12'h088, frame_done pulses with fb_we.
REQ-034 Assert rst_n=0 mid-pixel after a hit t=10 -> no write for that pixel; with STATS_EN, 3 hit pixels in a frame -> hit_count=3 after frame_done.
